// File: rtl/l2_cacheline_adaptor.sv
// rtl/l2_cacheline_adaptor.sv - L2 256-bit line to 4x64-bit memory burst adaptor
//
// Purpose:
//   Turns each L2 line read/write into a four-beat 64-bit burst on the
//   memory side and returns a single-cycle line response.
//   Optional feature macro: L2_ADAPTOR_CWF_EN (critical-word-first beat order).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pmem_address/read/write/wdata  line request from L2 (held until pmem_resp)
//   pmem_rdata, pmem_resp          assembled read line, one-cycle completion pulse
//   mem_address/read/write/wdata   burst request to memory
//   mem_rdata, mem_resp            beat data and one pulse per completed beat

module l2_cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_cnt;        // line slot of the current beat
  logic [1:0]    r_beats;      // beats completed so far in this burst
  logic [255:0]  r_wline_q;
  logic [255:0]  r_pmem_rdata;
  logic [63:0]   r_mem_wdata;
  logic [31:0]   r_mem_address;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_pmem_resp;

  logic [1:0]    w_start;
  logic [31:0]   w_burst_addr;
  logic          w_unused_addr_bits;

`ifdef L2_ADAPTOR_CWF_EN
  // Burst starts at the requested 64-bit word and wraps around the line.
  assign w_start            = pmem_address[4:3];
  assign w_burst_addr       = {pmem_address[31:3], 3'b000};
  assign w_unused_addr_bits = ^pmem_address[2:0];
`else
  assign w_start            = 2'd0;
  assign w_burst_addr       = {pmem_address[31:5], 5'b00000};
  assign w_unused_addr_bits = ^pmem_address[4:0];
`endif

  function automatic logic [63:0] f_slot(input logic [255:0] line, input logic [1:0] idx);
    return line[{idx, 6'b000000} +: 64];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 2'd0;
      r_beats       <= 2'd0;
      r_wline_q     <= '0;
      r_pmem_rdata  <= '0;
      r_mem_wdata   <= '0;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_pmem_resp   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pmem_write || pmem_read) begin
            r_wline_q     <= pmem_wdata;
            r_mem_address <= w_burst_addr;
            r_cnt         <= w_start;
            r_beats       <= 2'd0;
            // Write wins; a concurrent read stays pending for a later IDLE.
            if (pmem_write) begin
              r_state     <= S_WR;
              r_mem_write <= 1'b1;
              r_mem_wdata <= f_slot(pmem_wdata, w_start);
            end else begin
              r_state     <= S_RD;
              r_mem_read  <= 1'b1;
            end
          end
        end

        S_RD: begin
          if (mem_resp) begin
            r_pmem_rdata[{r_cnt, 6'b000000} +: 64] <= mem_rdata;
            r_cnt   <= r_cnt + 2'd1;
            r_beats <= r_beats + 2'd1;
            if (r_beats == 2'd3) begin
              r_mem_read  <= 1'b0;
              r_pmem_resp <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end

        S_WR: begin
          if (mem_resp) begin
            r_cnt       <= r_cnt + 2'd1;
            r_beats     <= r_beats + 2'd1;
            r_mem_wdata <= f_slot(r_wline_q, r_cnt + 2'd1);
            if (r_beats == 2'd3) begin
              r_mem_write <= 1'b0;
              r_pmem_resp <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_pmem_resp <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pmem_rdata  = r_pmem_rdata;
  assign pmem_resp   = r_pmem_resp;
  assign mem_address = r_mem_address;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb/tb_l2_cacheline_adaptor.sv - scoreboard bench for l2_cacheline_adaptor

module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  l2_cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_wr;
    logic [255:0] line;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  rd_beats_q[$];
  logic [63:0]  exp_wbeat_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [255:0] last_rd = '0;
  logic [31:0]  cur_addr = '0;
  int           gap_max = 0;
  int           beats_given = 0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules: where the burst starts and which address it presents.
  function automatic int start_beat(input logic [31:0] a);
`ifdef L2_ADAPTOR_CWF_EN
    return int'((a >> 3) % 4);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_maddr(input logic [31:0] a);
`ifdef L2_ADAPTOR_CWF_EN
    return (a / 8) * 8;
`else
    return (a / 32) * 32;
`endif
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [63:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  // Beat i of a burst belongs to line slot (start + i) mod 4.
  task automatic queue_expect(input bit is_wr, input logic [31:0] a, input logic [255:0] wd,
                              input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0]  b[4];
    logic [255:0] line;
    exp_t         e;
    int           s;
    int           slot;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    line = '0;
    s = start_beat(a);
    for (int i = 0; i < 4; i++) begin
      slot = (s + i) % 4;
      if (is_wr) exp_wbeat_q.push_back(wd[slot*64 +: 64]);
      else begin
        rd_beats_q.push_back(b[i]);
        line[slot*64 +: 64] = b[i];
      end
    end
    exp_addr_q.push_back(exp_maddr(a));
    e.is_wr = is_wr;
    e.line  = line;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pmem_resp && cyc < 300);
    if (!pmem_resp) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no pmem_resp within %0d cycles", name, cyc);
    end
  endtask

  task automatic run_txn(input bit is_wr, input logic [31:0] a, input logic [255:0] wd, input int gap);
    int cyc;
    gap_max = gap;
    queue_expect(is_wr, a, wd, rand_beat(), rand_beat(), rand_beat(), rand_beat());
    pmem_address = a;
    pmem_wdata   = wd;
    pmem_write   = is_wr;
    pmem_read    = !is_wr;
    wait_resp(is_wr ? "wr_txn" : "rd_txn", cyc);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  // Memory responder: random gaps, checks address and write beat at each ack.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !(mem_read || mem_write)) begin
        mem_resp    = 1'b0;
        beats_given = 0;
      end else if (beats_given < 4 && $urandom_range(0, gap_max) == 0) begin
        if (beats_given == 0 && exp_addr_q.size() > 0) cur_addr = exp_addr_q.pop_front();
        chk("mem_address", 256'(mem_address), 256'(cur_addr));
        if (mem_write) begin
          if (exp_wbeat_q.size() > 0) chk("mem_wdata", 256'(mem_wdata), 256'(exp_wbeat_q.pop_front()));
          else chk("wbeat_unexpected", 256'(1), 256'(0));
        end else begin
          mem_rdata = (rd_beats_q.size() > 0) ? rd_beats_q.pop_front() : 64'd0;
        end
        mem_resp = 1'b1;
        beats_given++;
      end else begin
        mem_resp = 1'b0;
      end
    end
  end

  // Monitor: line responses and strobe exclusivity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) chk("strobe_excl", 256'(mem_read && mem_write), 256'(0));
      if (pmem_resp) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 256'(1), 256'(0));
        else begin
          e = exp_q.pop_front();
          if (e.is_wr) chk("rdata_kept_on_write", pmem_rdata, last_rd);
          else begin
            chk("pmem_rdata", pmem_rdata, e.line);
            last_rd = e.line;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [255:0] wd;
    logic [31:0]  a;
    bit           wr;

    // Reset held two cycles with a read pending, then zero-wait read.
    rst          = 1'b1;
    pmem_read    = 1'b1;
    pmem_write   = 1'b0;
    pmem_address = 32'h0000_1040;
    pmem_wdata   = '0;
    gap_max      = 0;
    queue_expect(1'b0, 32'h0000_1040, '0, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_read", 256'(mem_read), 256'(0));
      chk("rst_outputs", {mem_write, pmem_resp, mem_address, mem_wdata}, '0);
      chk("rst_rdata", pmem_rdata, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rd_strobe_rise", 256'(mem_read), 256'(1));
    wait_resp("zero_wait_rd", cyc);
    chk("zero_wait_latency", 256'(cyc + 1), 256'(5));
    chk("zero_wait_line", pmem_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    pmem_read = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", 256'(pmem_resp), 256'(0));

    // Write with gaps, beats A,B,C,D in slot order.
    wd = {64'hD, 64'hC, 64'hB, 64'hA};
    run_txn(1'b1, 32'h0000_2000, wd, 3);

    // Simultaneous requests: write first, then the pending read.
    gap_max = 2;
    wd = rand_line();
    queue_expect(1'b1, 32'h0000_3020, wd, '0, '0, '0, '0);
    queue_expect(1'b0, 32'h0000_3020, '0, rand_beat(), rand_beat(), rand_beat(), rand_beat());
    pmem_address = 32'h0000_3020;
    pmem_wdata   = wd;
    pmem_write   = 1'b1;
    pmem_read    = 1'b1;
    wait_resp("simul_wr", cyc);
    pmem_write = 1'b0;
    wait_resp("simul_rd", cyc);
    pmem_read = 1'b0;

    // Reset during a read burst.
    gap_max = 0;
    queue_expect(1'b0, 32'h0000_4000, '0, rand_beat(), rand_beat(), rand_beat(), rand_beat());
    pmem_address = 32'h0000_4000;
    pmem_read    = 1'b1;
    cyc = 0;
    while (beats_given < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    rst       = 1'b1;
    pmem_read = 1'b0;
    @(negedge clk);
    chk("abort_mem_read", 256'(mem_read), 256'(0));
    chk("abort_rdata", pmem_rdata, '0);
    chk("abort_no_resp", 256'(pmem_resp), 256'(0));
    void'(exp_q.pop_back());
    rd_beats_q.delete();
    exp_addr_q.delete();
    last_rd = '0;
    rst = 1'b0;
    @(negedge clk);

    // Critical-word-first address; beats land in wrap order.
    run_txn(1'b0, 32'h0000_1050, '0, 1);
    chk("cwf_addr_rule", 256'(cur_addr), 256'(exp_maddr(32'h0000_1050)));

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      wr = $urandom_range(0, 1);
      a  = $urandom;
      run_txn(wr, a, rand_line(), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
